// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - command, status and state definitions shared by calc_seq
package calc_pkg;

    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_DIV  = 4'hD;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_BKSP = 4'hF;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_COMPUTE,
        S_CONVERT,
        S_EMIT,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest value representable with n decimal digits.
    function automatic longint dec_max(input int n);
        longint v;
        v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one input bit per cycle
module bin2bcd_seq #(
    parameter int VAL_W      = 27,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);

    logic [VAL_W-1:0]        r_sh;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [4*NUM_DIGITS-1:0] w_adj;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_sh   <= bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sh  <= r_sh << 1;
                r_bcd <= (w_adj << 1) | {{(4*NUM_DIGITS-1){1'b0}}, r_sh[VAL_W-1]};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - keypad calculator: operand entry, iterative arithmetic, digit streaming
module calc_seq
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 27,
    parameter int POS_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic [1:0]       status,
    output logic [3:0]       data,
    output logic [POS_W-1:0] pos,
    output logic             disp_we,
    output logic             disp_clr
);

    localparam int CNT_W = $clog2(VAL_W);
    localparam int PW    = 2 * VAL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);
    localparam logic [PW-1:0]    MAX_W    = PW'(dec_max(NUM_DIGITS));
    localparam logic [POS_W:0]   N_DIG    = (POS_W + 1)'(NUM_DIGITS);

    state_t r_state, w_state_nxt;

    logic [VAL_W-1:0] r_opA, r_opB, r_acc, r_hi, r_lo;
    logic [3:0]       r_op, r_data, r_pend_data;
    logic [POS_W:0]   r_count, r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_we, r_clr, r_conv_start, r_pend;

    logic                    w_cmd_ok, w_is_digit, w_is_op, w_rge, w_last, w_fin, w_err;
    logic [VAL_W-1:0]        w_opnd, w_opnd_push, w_opnd_pop, w_rnew, w_quo;
    logic [VAL_W:0]          w_sum_add, w_mul_sum, w_rsh;
    logic [PW-1:0]           w_res;
    logic [POS_W:0]          w_count_dec;
    logic [3:0]              w_digit;
    logic                    w_conv_done;
    logic [4*NUM_DIGITS-1:0] w_bcd;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (r_conv_start),
        .bin   (r_acc),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // The cycle after a DONE+digit restart carries the deferred write, so keys are held off.
    always_comb begin
        w_cmd_ok    = cmd_valid && !r_pend;
        w_is_digit  = (cmd <= 4'd9);
        w_is_op     = (cmd >= CMD_ADD) && (cmd <= CMD_DIV);
        w_opnd      = (r_state == S_ENTER_B) ? r_opB : r_opA;
        w_opnd_push = w_opnd * VAL_W'(10) + VAL_W'(cmd);
        w_opnd_pop  = w_opnd / VAL_W'(10);
        w_count_dec = r_count - 1'b1;
        w_sum_add   = {1'b0, r_opA} + {1'b0, r_opB};
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opA} : '0);
        w_rsh       = {r_hi, r_lo[VAL_W-1]};
        w_rge       = (w_rsh >= {1'b0, r_opB});
        w_rnew      = w_rge ? VAL_W'(w_rsh - {1'b0, r_opB}) : w_rsh[VAL_W-1:0];
        w_quo       = {r_lo[VAL_W-2:0], w_rge};
        w_last      = (r_cnt == CNT_LAST);
        w_res       = '0;
        w_fin       = 1'b0;
        w_err       = 1'b0;
        case (r_op)
            CMD_ADD: begin w_res = PW'(w_sum_add);     w_fin = 1'b1; end
            CMD_SUB: begin w_res = PW'(r_opA - r_opB); w_fin = 1'b1; w_err = (r_opA < r_opB); end
            CMD_MUL: begin w_res = {w_mul_sum, r_lo[VAL_W-1:1]}; w_fin = w_last; end
            default: begin w_res = PW'(w_quo); w_fin = w_last; w_err = (r_opB == '0); end
        endcase
        if (w_fin && (w_res > MAX_W)) w_err = 1'b1;
        w_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == (POS_W + 1)'(i)) w_digit = w_bcd[4*(NUM_DIGITS-1-i) +: 4];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_ENTER_A;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        status      = ST_IDLE;
        case (r_state)
            S_ENTER_A: if (w_cmd_ok && w_is_op) w_state_nxt = S_ENTER_B;
            S_ENTER_B: begin
                if (w_cmd_ok && cmd == CMD_EQ) w_state_nxt = S_COMPUTE;
                else if (w_cmd_ok && w_is_op)  w_state_nxt = S_ERROR;
            end
            S_COMPUTE: begin
                status = ST_BUSY;
                if (w_err)      w_state_nxt = S_ERROR;
                else if (w_fin) w_state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                status = ST_BUSY;
                if (w_conv_done) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                status = ST_BUSY;
                if (r_idx == N_DIG) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                status = ST_READY;
                if (w_cmd_ok && w_is_op)         w_state_nxt = S_ENTER_B;
                else if (w_cmd_ok && w_is_digit) w_state_nxt = S_ENTER_A;
            end
            default: status = ST_ERR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_opA        <= '0;
            r_opB        <= '0;
            r_acc        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_op         <= CMD_ADD;
            r_count      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_pos        <= '0;
            r_we         <= 1'b0;
            r_clr        <= 1'b0;
            r_conv_start <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_we         <= 1'b0;
            r_clr        <= 1'b0;
            r_conv_start <= 1'b0;
            r_pend       <= 1'b0;
            case (r_state)
                S_ENTER_A, S_ENTER_B: begin
                    if (r_pend) begin
                        r_we   <= 1'b1;
                        r_pos  <= '0;
                        r_data <= r_pend_data;
                    end
                    if (w_cmd_ok) begin
                        if (w_is_digit && r_count < N_DIG) begin
                            if (r_state == S_ENTER_B) r_opB <= w_opnd_push;
                            else                      r_opA <= w_opnd_push;
                            r_we    <= 1'b1;
                            r_pos   <= r_count[POS_W-1:0];
                            r_data  <= cmd;
                            r_count <= r_count + 1'b1;
                        end else if (cmd == CMD_BKSP && r_count != '0) begin
                            if (r_state == S_ENTER_B) r_opB <= w_opnd_pop;
                            else                      r_opA <= w_opnd_pop;
                            r_we    <= 1'b1;
                            r_pos   <= w_count_dec[POS_W-1:0];
                            r_data  <= '0;
                            r_count <= w_count_dec;
                        end else if (w_is_op && r_state == S_ENTER_A) begin
                            r_op    <= cmd;
                            r_count <= '0;
                            r_clr   <= 1'b1;
                            r_opB   <= '0;
                        end else if (cmd == CMD_EQ && r_state == S_ENTER_B) begin
                            r_hi  <= '0;
                            r_lo  <= (r_op == CMD_DIV) ? r_opA : r_opB;
                            r_cnt <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!w_err) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op == CMD_MUL) begin
                            r_hi <= w_mul_sum[VAL_W:1];
                            r_lo <= {w_mul_sum[0], r_lo[VAL_W-1:1]};
                        end else if (r_op == CMD_DIV) begin
                            r_hi <= w_rnew;
                            r_lo <= w_quo;
                        end
                        if (w_fin) begin
                            r_acc        <= w_res[VAL_W-1:0];
                            r_conv_start <= 1'b1;
                        end
                    end
                end
                S_CONVERT: begin
                    if (w_conv_done) begin
                        r_clr <= 1'b1;
                        r_idx <= '0;
                    end
                end
                S_EMIT: begin
                    if (r_idx < N_DIG) begin
                        r_we   <= 1'b1;
                        r_pos  <= r_idx[POS_W-1:0];
                        r_data <= w_digit;
                        r_idx  <= r_idx + 1'b1;
                    end else begin
                        r_opA   <= r_acc;
                        r_count <= '0;
                    end
                end
                S_DONE: begin
                    if (w_cmd_ok && w_is_op) begin
                        r_op    <= cmd;
                        r_clr   <= 1'b1;
                        r_opB   <= '0;
                        r_count <= '0;
                    end else if (w_cmd_ok && w_is_digit) begin
                        r_opA       <= VAL_W'(cmd);
                        r_count     <= (POS_W + 1)'(1);
                        r_clr       <= 1'b1;
                        r_pend      <= 1'b1;
                        r_pend_data <= cmd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data     = r_data;
    assign pos      = r_pos;
    assign disp_we  = r_we;
    assign disp_clr = r_clr;

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
Parametrised successor to the single-operand-pair calculator FSM. Accepts keypad commands with a valid strobe and builds two decimal operands of up to NUM_DIGITS digits. Performs add, subtract, multiply (iterative shift-add) or divide (iterative restoring). Streams the decimal result to the display controller one digit per cycle, supports chaining a result into the next operation, and reports overflow and divide-by-zero as errors.

Parameters:
NUM_DIGITS, 8, maximum decimal digits per operand and result; legal range 2..8.
VAL_W, 27, binary width of operand and result registers; must satisfy 2^VAL_W > 10^NUM_DIGITS - 1.
POS_W, 3, width of pos; must satisfy 2^POS_W >= NUM_DIGITS.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd  in  4  command code: 0-9 digit, A add, B sub, C mul, D div, E equals, F backspace
cmd_valid  in  1  one-cycle strobe; cmd sampled only when high
status  out  2  00 error, 01 busy, 10 result ready, 11 idle/entering
data  out  4  BCD digit to write to display
pos  out  POS_W  display position; 0 = leftmost
disp_we  out  1  one-cycle write strobe for data/pos
disp_clr  out  1  one-cycle pulse that blanks all display digits

Behaviour:
- Reset (async, active-high; clock single domain): state ENTER_A, status=11, data=0, pos=0, disp_we=0, disp_clr=0, regA=regB=acc=0, digit count=0, op=add.
- States: ENTER_A, ENTER_B, COMPUTE, CONVERT, EMIT, DONE, ERROR.
- ENTER_A / ENTER_B digit, count<NUM_DIGITS: operand <= operand*10+cmd. Next cycle: disp_we=1, pos=count, data=cmd. count+1.
- Digit with count==NUM_DIGITS: ignored, no write.
- Backspace, count>0: operand <= operand/10, count-1. Write data=0 at pos=count-1.
- Backspace, count==0: ignored.
- ENTER_A operator (A-D): latch op, regA kept, count=0, disp_clr pulse, go ENTER_B.
- E in ENTER_A: ignored.
- ENTER_B E: go COMPUTE, status=01.
- ENTER_B operator: go ERROR.
- cmd_valid while in COMPUTE/CONVERT/EMIT: ignored entirely.
- COMPUTE add: 1 cycle.
- COMPUTE sub: 1 cycle; regA<regB goes to ERROR (negative results unsupported).
- COMPUTE mul: shift-add over regB bits, exactly VAL_W cycles.
- COMPUTE div: restoring division, exactly VAL_W cycles, quotient only. regB==0 goes to ERROR in the first COMPUTE cycle.
- Overflow check after COMPUTE: any result > 10^NUM_DIGITS-1 (including mul carry beyond VAL_W) goes to ERROR.
- CONVERT: sequential double-dabble, VAL_W cycles, start/done handshake with the sub-module.
- EMIT: exactly NUM_DIGITS consecutive cycles with disp_we=1. Digits are written most significant first with leading zeros, pos 0..NUM_DIGITS-1. disp_clr pulses in the cycle entering EMIT.
- DONE: status=10 from the cycle after the last write. regA <= result, count=0.
- DONE + operator: chain (regA=result), disp_clr, go ENTER_B.
- DONE + digit: regA restarts at 0 with that digit, disp_clr, go ENTER_A, status=11.
- DONE + E or F: ignored.
- ERROR: status=00, disp_we=0, sticky; only reset exits.
- disp_we and disp_clr are never high in the same cycle.
- Reset mid-operation: immediate return to reset values; no partial writes after reset deasserts.

Decomposition:
- calc_pkg: cmd code constants (CMD_ADD..CMD_BKSP), status constants (ST_ERR, ST_BUSY, ST_READY, ST_IDLE), state enum type.
- One sub-module, bin2bcd_seq: parametrised VAL_W/NUM_DIGITS, ports start/done, input bin, output bcd.

Test Plan:
- Digits 1,2; A; 3,4; E -> writes pos0..7 = 0,0,0,0,0,0,4,6; status 01 during compute, then 10.
- 7 C 6 E -> mul busy VAL_W cycles, output ...0042. Then D 5 E (chain) -> ...0008, status 10.
- 1,0,0 D 0 E -> status 00; later cmds ignored until reset, then status 11.
- 5 B 9 E -> ERROR. 99999999 C 2 E -> overflow ERROR.
- Nine digits 9 entered -> 9th ignored (8 writes only). F -> write 0 at pos 7, operand 9999999. F at count 0 -> no write.
- Reset asserted mid-multiply -> status 11, disp_we 0 same cycle. Fresh 2 A 3 E then gives 5.
